// File: rtl/counter_bank_if.sv
// Strobe/value bus and status outputs of the counter bank.
interface counter_bank_if #(
    parameter int unsigned C_CHANNELS = 4,
    parameter int unsigned C_WIDTH    = 16
);
    logic [C_CHANNELS-1:0]         load;
    logic [C_CHANNELS-1:0]         incr;
    logic [C_CHANNELS-1:0]         decr;
    logic [C_CHANNELS*C_WIDTH-1:0] load_value;
    logic [C_CHANNELS*C_WIDTH-1:0] stride_value;
    logic [C_CHANNELS*C_WIDTH-1:0] threshold_value;
    logic [C_CHANNELS*C_WIDTH-1:0] count;
    logic [C_CHANNELS-1:0]         is_zero;
    logic [C_CHANNELS-1:0]         overflow;
    logic [C_CHANNELS-1:0]         threshold_hit;
    logic                          all_zero;

    modport master (
        output load, incr, decr, load_value, stride_value, threshold_value,
        input  count, is_zero, overflow, threshold_hit, all_zero
    );

    modport slave (
        input  load, incr, decr, load_value, stride_value, threshold_value,
        output count, is_zero, overflow, threshold_hit, all_zero
    );
endinterface

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with per-channel load, stride and
// threshold; wrap or saturate selected per instance.
module counter_bank #(
    parameter int unsigned         C_CHANNELS = 4,
    parameter int unsigned         C_WIDTH    = 16,
    parameter logic [C_WIDTH-1:0]  C_INIT     = '0,
    parameter logic [C_WIDTH-1:0]  S_INIT     = {{(C_WIDTH-1){1'b0}}, 1'b1},
    parameter bit                  C_SATURATE = 1'b0
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_clken,
    counter_bank_if.slave        bus
);

    logic [C_WIDTH-1:0] cnt_arr  [C_CHANNELS];
    logic               zero_arr [C_CHANNELS];
    logic               ovf_arr  [C_CHANNELS];
    logic               hit_arr  [C_CHANNELS];

    for (genvar i = 0; i < C_CHANNELS; i++) begin : g_chan
        logic [C_WIDTH-1:0] cnt_q;
        logic [C_WIDTH-1:0] str_q;
        logic [C_WIDTH-1:0] thr_q;
        logic               zero_q;
        logic               ovf_q;
        logic               hit_q;

        logic [C_WIDTH:0]   sum;
        logic [C_WIDTH-1:0] diff;
        logic [C_WIDTH-1:0] nxt;
        logic               carry;
        logic               borrow;
        logic               do_inc;
        logic               do_dec;

        // Next count for an incr/decr step, with carry/borrow detection
        always_comb begin
            sum    = {1'b0, cnt_q} + {1'b0, str_q};
            carry  = sum[C_WIDTH];
            borrow = (str_q > cnt_q);
            diff   = cnt_q - str_q;
            do_inc = bus.incr[i] & ~bus.decr[i];
            do_dec = bus.decr[i] & ~bus.incr[i];
            nxt    = cnt_q;
            if (do_inc) begin
                nxt = (C_SATURATE && carry) ? '1 : sum[C_WIDTH-1:0];
            end else if (do_dec) begin
                nxt = (C_SATURATE && borrow) ? '0 : diff;
            end
        end

        // Channel state: reset > clock enable > load > incr/decr > hold
        always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
                cnt_q  <= C_INIT;
                str_q  <= S_INIT;
                thr_q  <= '1;
                zero_q <= (C_INIT == '0);
                ovf_q  <= 1'b0;
                hit_q  <= 1'b0;
            end else if (ap_clken) begin
                if (bus.load[i]) begin
                    cnt_q  <= bus.load_value[i*C_WIDTH +: C_WIDTH];
                    str_q  <= bus.stride_value[i*C_WIDTH +: C_WIDTH];
                    thr_q  <= bus.threshold_value[i*C_WIDTH +: C_WIDTH];
                    zero_q <= (bus.load_value[i*C_WIDTH +: C_WIDTH] == '0);
                    ovf_q  <= 1'b0;
                    hit_q  <= 1'b0;
                end else begin
                    cnt_q  <= nxt;
                    zero_q <= (nxt == '0);
                    hit_q  <= (do_inc || do_dec) && (nxt == thr_q);
                    if ((do_inc && carry) || (do_dec && borrow)) begin
                        ovf_q <= 1'b1;
                    end
                end
            end
        end

        assign cnt_arr[i]  = cnt_q;
        assign zero_arr[i] = zero_q;
        assign ovf_arr[i]  = ovf_q;
        assign hit_arr[i]  = hit_q;
    end

    // Pack per-channel registers onto the bus outputs
    always_comb begin
        bus.count         = '0;
        bus.is_zero       = '0;
        bus.overflow      = '0;
        bus.threshold_hit = '0;
        for (int unsigned i = 0; i < C_CHANNELS; i++) begin
            bus.count[i*C_WIDTH +: C_WIDTH] = cnt_arr[i];
            bus.is_zero[i]                  = zero_arr[i];
            bus.overflow[i]                 = ovf_arr[i];
            bus.threshold_hit[i]            = hit_arr[i];
        end
        bus.all_zero = &bus.is_zero;
    end

endmodule
